// File: rtl/lsu.sv
// Load/store unit: runs one request/ready transaction per memory instruction
// against byte-laned data memory and stalls the core until it completes.
// Optional build macro: LSU_MISALIGN_CHECK_EN enables misaligned-access detection
// (halfword with a[0]=1, word with a!=0) which suppresses the access.
module lsu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] ALUout,
    input  logic [31:0] WD,
    output logic [31:0] RDout,
    output logic        Done,
    output logic        Stall,
    output logic        MisAlign,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_reg, state_next;
    logic [31:0] addr_reg;
    logic [3:0]  be_reg;
    logic [31:0] wdata_reg;
    logic        we_reg;
    logic [1:0]  a_reg;
    logic        byte_reg, half_reg, uns_reg;
    logic [31:0] rdata_reg;

    logic        is_byte, is_half, is_unsigned, access;
    logic        misalign_raw, start;
    logic [1:0]  a_raw, eff_a;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [7:0]  lane_bytes [4];
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_ext;

    assign a_raw  = ALUout[1:0];
    assign access = MemRead | MemWrite;

    // Size/sign decode; undefined encodings fall through to word
    always_comb begin
        is_byte     = (funct3 == 3'b000) || (funct3 == 3'b100);
        is_half     = (funct3 == 3'b001) || (funct3 == 3'b101);
        is_unsigned = funct3[2] & (is_byte | is_half);
    end

`ifdef LSU_MISALIGN_CHECK_EN
    // Misaligned halfword/word accesses are flagged and never issued
    always_comb begin
        misalign_raw = (is_half & a_raw[0]) | (~is_byte & ~is_half & (a_raw != 2'b00));
        eff_a        = a_raw;
    end
`else
    // Without checking, low address bits below the access size are dropped
    always_comb begin
        misalign_raw = 1'b0;
        if (is_byte)
            eff_a = a_raw;
        else if (is_half)
            eff_a = {a_raw[1], 1'b0};
        else
            eff_a = 2'b00;
    end
`endif

    assign start = (state_reg == IDLE) & access & ~misalign_raw;

    // Byte-lane enables and lane-replicated store data for the new access
    always_comb begin
        if (is_byte) begin
            be_new    = 4'b0001 << eff_a;
            wdata_new = {4{WD[7:0]}};
        end else if (is_half) begin
            be_new    = eff_a[1] ? 4'b1100 : 4'b0011;
            wdata_new = {2{WD[15:0]}};
        end else begin
            be_new    = 4'b1111;
            wdata_new = WD;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Capture the request at issue and the read data at completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg  <= '0;
            be_reg    <= '0;
            wdata_reg <= '0;
            we_reg    <= 1'b0;
            a_reg     <= '0;
            byte_reg  <= 1'b0;
            half_reg  <= 1'b0;
            uns_reg   <= 1'b0;
            rdata_reg <= '0;
        end else begin
            if (start) begin
                addr_reg  <= {ALUout[31:2], 2'b00};
                be_reg    <= be_new;
                wdata_reg <= wdata_new;
                we_reg    <= MemWrite;
                a_reg     <= eff_a;
                byte_reg  <= is_byte;
                half_reg  <= is_half;
                uns_reg   <= is_unsigned;
            end
            if ((state_reg == BUSY) && mem_ready && !we_reg)
                rdata_reg <= mem_rdata;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = BUSY;
            BUSY:    if (mem_ready) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Split the captured read word into its byte lanes
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_bytes[gi] = rdata_reg[8*gi +: 8];
        end
    endgenerate

    // Extract and extend the load result from the captured lane
    always_comb begin
        ld_byte = lane_bytes[a_reg];
        ld_half = a_reg[1] ? rdata_reg[31:16] : rdata_reg[15:0];
        if (byte_reg)
            load_ext = uns_reg ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
        else if (half_reg)
            load_ext = uns_reg ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
        else
            load_ext = rdata_reg;
    end

    // Outputs; reset forces the combinational terms low at once
    always_comb begin
        Stall     = rst_n & (start | (state_reg == BUSY));
        MisAlign  = rst_n & (state_reg == IDLE) & access & misalign_raw;
        Done      = (state_reg == DONE);
        mem_req   = (state_reg == BUSY);
        mem_we    = mem_req & we_reg;
        mem_addr  = mem_req ? addr_reg  : '0;
        mem_be    = mem_req ? be_reg    : '0;
        mem_wdata = mem_req ? wdata_reg : '0;
        RDout     = (Done && !we_reg) ? load_ext : '0;
    end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: stimulus pushes expectations, monitor compares.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MemRead = 1'b0, MemWrite = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] ALUout = '0, WD = '0;
    logic [31:0] RDout;
    logic        Done, Stall, MisAlign, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;

    lsu dut (
        .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
        .funct3(funct3), .ALUout(ALUout), .WD(WD), .RDout(RDout), .Done(Done),
        .Stall(Stall), .MisAlign(MisAlign), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } mem_exp_t;
    typedef struct { logic [31:0] rd; int stall; } done_exp_t;
    typedef struct { int tag; logic stall, req, done, mis; logic [31:0] rd; } probe_t;

    mem_exp_t  mem_q[$];
    done_exp_t done_q[$];
    probe_t    probe_q[$];
    bit        stim_done = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Monitor: compares DUT outputs against queued expectations on the falling edge
    initial begin : monitor
        int stall_cnt;
        stall_cnt = 0;
        forever begin
            @(negedge clk);
            if (probe_q.size() > 0) begin
                probe_t p;
                p = probe_q.pop_front();
                $display("probe %0d: Stall=%b mem_req=%b Done=%b MisAlign=%b RDout=%h",
                         p.tag, Stall, mem_req, Done, MisAlign, RDout);
                chk($sformatf("probe%0d_stall", p.tag), {31'b0, Stall}, {31'b0, p.stall});
                chk($sformatf("probe%0d_req", p.tag), {31'b0, mem_req}, {31'b0, p.req});
                chk($sformatf("probe%0d_done", p.tag), {31'b0, Done}, {31'b0, p.done});
                chk($sformatf("probe%0d_mis", p.tag), {31'b0, MisAlign}, {31'b0, p.mis});
                chk($sformatf("probe%0d_rd", p.tag), RDout, p.rd);
            end
            if (!rst_n) begin
                mem_q.delete();
                done_q.delete();
                stall_cnt = 0;
            end else begin
                if (Stall) stall_cnt++;
                if (mem_req) begin
                    if (mem_q.size() == 0) begin
                        chk("unexpected_req", {31'b0, mem_req}, 32'd0);
                    end else begin
                        mem_exp_t m;
                        m = mem_q[0];
                        chk("mem_addr", mem_addr, m.addr);
                        chk("mem_be", {28'b0, mem_be}, {28'b0, m.be});
                        chk("mem_we", {31'b0, mem_we}, {31'b0, m.we});
                        if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
                        if (mem_ready) begin
                            void'(mem_q.pop_front());
                            $display("mem xfer: we=%b addr=%h be=%b wdata=%h",
                                     mem_we, mem_addr, mem_be, mem_wdata);
                        end
                    end
                end
                if (Done) begin
                    if (done_q.size() == 0) begin
                        chk("unexpected_done", {31'b0, Done}, 32'd0);
                    end else begin
                        done_exp_t d;
                        d = done_q.pop_front();
                        $display("done: RDout=%h stall_cycles=%0d", RDout, stall_cnt);
                        chk("rdout", RDout, d.rd);
                        chk("stall_cycles", stall_cnt, d.stall);
                        chk("stall_in_done", {31'b0, Stall}, 32'd0);
                    end
                    stall_cnt = 0;
                end
                if (stall_cnt > 60) begin
                    chk("stall_watchdog", stall_cnt, 32'd0);
                    stall_cnt = 0;
                end
            end
            if (stim_done) begin
                chk("mem_q_left", mem_q.size(), 32'd0);
                chk("done_q_left", done_q.size(), 32'd0);
                chk("stall_leftover", stall_cnt, 32'd0);
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    end

    task automatic push_probe(input int tag, input logic st, input logic rq,
                              input logic dn, input logic ms, input logic [31:0] rd);
        probe_t p;
        p.tag = tag; p.stall = st; p.req = rq; p.done = dn; p.mis = ms; p.rd = rd;
        probe_q.push_back(p);
    endtask

    // Issue one access and let the DUT run it; waits = BUSY cycles with mem_ready low
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rdata, input int waits,
                             input logic [31:0] e_addr, input logic [3:0] e_be,
                             input logic [31:0] e_wdata, input logic [31:0] e_rd);
        mem_exp_t  m;
        done_exp_t d;
        int n;
        m.we = wr; m.addr = e_addr; m.be = e_be; m.wdata = e_wdata;
        d.rd = e_rd; d.stall = waits + 2;
        mem_q.push_back(m);
        done_q.push_back(d);
        @(posedge clk); #1;
        MemRead = rd; MemWrite = wr; funct3 = f3; ALUout = addr; WD = wd;
        mem_rdata = rdata; mem_ready = 1'b0;
        push_probe(1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (Done) break;
            if (mem_req) begin
                mem_ready = (n >= waits);
                n++;
            end
        end
        MemRead = 1'b0; MemWrite = 1'b0; mem_ready = 1'b0;
    endtask

    // Stimulus
    initial begin : stimulus
        repeat (2) @(posedge clk);
        #1 push_probe(0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;

        // word load
        do_access(1, 0, 3'b010, 32'h104, 32'h0, 32'hDEADBEEF, 0, 32'h104, 4'b1111, 32'h0, 32'hDEADBEEF);
        // LB / LBU on lane 3
        do_access(1, 0, 3'b000, 32'h203, 32'h0, 32'h80112233, 0, 32'h200, 4'b1000, 32'h0, 32'hFFFFFF80);
        do_access(1, 0, 3'b100, 32'h203, 32'h0, 32'h80112233, 0, 32'h200, 4'b1000, 32'h0, 32'h00000080);
        // half store with 3 wait states
        do_access(0, 1, 3'b001, 32'h302, 32'h0000ABCD, 32'h0, 3, 32'h300, 4'b1100, 32'hABCDABCD, 32'h0);
        // LH / LHU upper half, LH lower half
        do_access(1, 0, 3'b001, 32'h002, 32'h0, 32'h80112233, 0, 32'h000, 4'b1100, 32'h0, 32'hFFFF8011);
        do_access(1, 0, 3'b101, 32'h002, 32'h0, 32'h80112233, 0, 32'h000, 4'b1100, 32'h0, 32'h00008011);
        do_access(1, 0, 3'b001, 32'h000, 32'h0, 32'h80112233, 1, 32'h000, 4'b0011, 32'h0, 32'h00002233);
        // byte store lane 1 with one wait
        do_access(0, 1, 3'b000, 32'h001, 32'h000000A5, 32'h0, 1, 32'h000, 4'b0010, 32'hA5A5A5A5, 32'h0);
        // read and write both high: write wins, RDout 0
        do_access(1, 1, 3'b010, 32'h040, 32'h12345678, 32'hFFFFFFFF, 0, 32'h040, 4'b1111, 32'h12345678, 32'h0);
        // undefined funct3 behaves as word
        do_access(1, 0, 3'b011, 32'h008, 32'h0, 32'h0F0F0F0F, 0, 32'h008, 4'b1111, 32'h0, 32'h0F0F0F0F);
        // positive byte, lane 0
        do_access(1, 0, 3'b000, 32'h000, 32'h0, 32'h0000007F, 0, 32'h000, 4'b0001, 32'h0, 32'h0000007F);

        // non-memory instruction: idle, mem_ready ignored
        @(posedge clk); #1 mem_ready = 1'b1;
        push_probe(2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge clk); #1 mem_ready = 1'b0;

`ifdef LSU_MISALIGN_CHECK_EN
        // misaligned LW and LH: flagged, no request, no stall
        @(posedge clk); #1;
        MemRead = 1'b1; funct3 = 3'b010; ALUout = 32'h101; mem_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            push_probe(3, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
            @(posedge clk); #1;
        end
        funct3 = 3'b001; ALUout = 32'h003;
        push_probe(4, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        @(posedge clk); #1 MemRead = 1'b0; mem_ready = 1'b0;
`else
        // without checking, low bits are dropped and the access proceeds
        do_access(1, 0, 3'b010, 32'h101, 32'h0, 32'h11223344, 0, 32'h100, 4'b1111, 32'h0, 32'h11223344);
        do_access(1, 0, 3'b001, 32'h003, 32'h0, 32'h80112233, 0, 32'h000, 4'b1100, 32'h0, 32'hFFFF8011);
`endif

        // reset mid-BUSY: request dropped at once, then idle after release
        begin
            mem_exp_t m;
            m.we = 1'b0; m.addr = 32'h500; m.be = 4'b1111; m.wdata = 32'h0;
            mem_q.push_back(m);
        end
        @(posedge clk); #1;
        MemRead = 1'b1; funct3 = 3'b010; ALUout = 32'h500; mem_ready = 1'b0;
        push_probe(5, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        push_probe(6, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge clk); #1 MemRead = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        push_probe(7, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        // a normal access after reset proves the FSM is back in IDLE
        do_access(1, 0, 3'b000, 32'h602, 32'h0, 32'h00FE0000, 0, 32'h600, 4'b0100, 32'h0, 32'hFFFFFFFE);

        @(posedge clk); #1 stim_done = 1'b1;
    end

    // Absolute time limit
    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
